pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and next-PC sequencer. Owns the instruction-fetch
// handshake, selects PC+4 or the jump/branch target, and parks in a trap
// state on a misaligned taken target or an instruction-memory timeout.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode,
    input  logic        branch_taken,
    input  logic [31:0] jb_target,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        trap_clear,
    input  logic [31:0] trap_vec,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic        instr_valid,
    output logic        redirect,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_pc
);

    // opcode[6:2] encodings of the control-transfer classes
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // wait_cnt value on which a further not-ready cycle becomes a timeout
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StTrap
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_pc,        w_pc_nxt;
    logic [7:0]  r_wait_cnt,  w_wait_cnt_nxt;
    logic        r_redirect,  w_redirect_nxt;
    logic [1:0]  r_exc_cause, w_exc_cause_nxt;
    logic [31:0] r_exc_pc,    w_exc_pc_nxt;

    logic        w_take;
    logic        w_accept;
    logic        w_misaligned;
    logic [31:0] w_pc_plus4;

    assign w_take = (opcode == OPC_JAL) | (opcode == OPC_JALR) |
                    ((opcode == OPC_BRANCH) & branch_taken);
    assign w_accept     = imem_ready & ~stall;
    assign w_misaligned = ALIGN_CHECK & (|jb_target[1:0]);
    assign w_pc_plus4   = r_pc + 32'd4;

    // State register and all sequential bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StBoot;
            r_pc        <= RESET_PC;
            r_wait_cnt  <= 8'd0;
            r_redirect  <= 1'b0;
            r_exc_cause <= CAUSE_NONE;
            r_exc_pc    <= 32'h0000_0000;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_redirect  <= w_redirect_nxt;
            r_exc_cause <= w_exc_cause_nxt;
            r_exc_pc    <= w_exc_pc_nxt;
        end
    end

    // Next-state, next-PC and trap capture
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_redirect_nxt  = 1'b0;
        w_exc_cause_nxt = r_exc_cause;
        w_exc_pc_nxt    = r_exc_pc;

        unique case (r_state)
            StBoot: begin
                w_state_nxt = StFetch;
            end
            StFetch: begin
                if (stall) begin
                    // hazard hold: nothing advances, including the timeout count
                end else if (imem_ready) begin
                    w_wait_cnt_nxt = 8'd0;
                    if (!w_take) begin
                        w_pc_nxt = w_pc_plus4;
                    end else if (w_misaligned) begin
                        w_exc_pc_nxt    = r_pc;
                        w_exc_cause_nxt = CAUSE_MISALIGN;
                        w_state_nxt     = StTrap;
                    end else begin
                        w_pc_nxt       = jb_target;
                        w_redirect_nxt = 1'b1;
                    end
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_wait_cnt_nxt  = 8'd0;
                    w_exc_pc_nxt    = r_pc;
                    w_exc_cause_nxt = CAUSE_TIMEOUT;
                    w_state_nxt     = StTrap;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            StTrap: begin
                if (trap_clear) begin
                    w_pc_nxt        = trap_vec;
                    w_exc_cause_nxt = CAUSE_NONE;
                    w_redirect_nxt  = 1'b1;
                    w_state_nxt     = StFetch;
                end
            end
            default: begin
                w_state_nxt = StBoot;
            end
        endcase
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign imem_req    = (r_state == StFetch);
    assign instr_valid = (r_state == StFetch) & w_accept;
    assign redirect    = r_redirect;
    assign exc_valid   = (r_state == StTrap);
    assign exc_cause   = r_exc_cause;
    assign exc_pc      = r_exc_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a cycle-level behavioural model
// checked against the DUT on every falling edge, plus directed literal checks.
module tb_pc_fetch_ctrl;

    localparam logic [4:0] OP_ALU = 5'b01100;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam int         TMO    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  opcode = OP_ALU;
    logic        branch_taken = 1'b0;
    logic [31:0] jb_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        trap_clear = 1'b0;
    logic [31:0] trap_vec = 32'h0;
    logic [31:0] pc, pc_plus4, exc_pc;
    logic        imem_req, instr_valid, redirect, exc_valid;
    logic [1:0]  exc_cause;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .ALIGN_CHECK (1'b1),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .jb_target    (jb_target),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .trap_clear   (trap_clear),
        .trap_vec     (trap_vec),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_req     (imem_req),
        .instr_valid  (instr_valid),
        .redirect     (redirect),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_pc       (exc_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = waiting for first clock, 1 = fetching, 2 = trapped
    int          m_mode  = 0;
    logic [31:0] m_pc    = 32'h0;
    int          m_miss  = 0;
    logic        m_redir = 1'b0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_epc   = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 32'h0; m_miss <= 0;
            m_redir <= 1'b0; m_cause <= 2'b00; m_epc <= 32'h0;
        end else begin
            m_redir <= 1'b0;
            if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1) begin
                if (stall) begin
                end else if (imem_ready) begin
                    m_miss <= 0;
                    if (!(opcode == JAL || opcode == JALR || (opcode == BRANCH && branch_taken)))
                        m_pc <= m_pc + 32'd4;
                    else if (jb_target % 4 != 0) begin
                        m_epc <= m_pc; m_cause <= 2'b01; m_mode <= 2;
                    end else begin
                        m_pc <= jb_target; m_redir <= 1'b1;
                    end
                end else if (m_miss + 1 == TMO) begin
                    m_miss <= 0; m_epc <= m_pc; m_cause <= 2'b10; m_mode <= 2;
                end else begin
                    m_miss <= m_miss + 1;
                end
            end else if (trap_clear) begin
                m_pc <= trap_vec; m_cause <= 2'b00; m_mode <= 1; m_redir <= 1'b1;
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        chk("m_pc", pc, m_pc);
        chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("m_imem_req", {31'b0, imem_req}, {31'b0, m_mode == 1});
        chk("m_instr_valid", {31'b0, instr_valid},
            {31'b0, m_mode == 1 && imem_ready && !stall});
        chk("m_redirect", {31'b0, redirect}, {31'b0, m_redir});
        chk("m_exc_valid", {31'b0, exc_valid}, {31'b0, m_mode == 2});
        chk("m_exc_cause", {30'b0, exc_cause}, {30'b0, m_cause});
        chk("m_exc_pc", exc_pc, m_epc);
    end

    task automatic cyc(input logic [4:0] op, input logic bt, input logic [31:0] tgt,
                       input logic st, input logic rdy, input logic tc,
                       input logic [31:0] vec);
        opcode = op; branch_taken = bt; jb_target = tgt; stall = st;
        imem_ready = rdy; trap_clear = tc; trap_vec = vec;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_redirect", {31'b0, redirect}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("boot_pc0", pc, 32'h0);
        chk("boot_valid", {31'b0, instr_valid}, 32'h1);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("seq_pc4", pc, 32'h4);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("seq_pc8", pc, 32'h8);
        chk("seq_redirect", {31'b0, redirect}, 32'h0);

        // Branch taken / not taken from 0x100
        cyc(JAL, 0, 32'h100, 0, 1, 0, 0);
        chk("jal_pc", pc, 32'h100);
        cyc(BRANCH, 1, 32'h80, 0, 1, 0, 0);
        chk("br_t_pc", pc, 32'h80);
        chk("br_t_redirect", {31'b0, redirect}, 32'h1);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("redirect_drop", {31'b0, redirect}, 32'h0);
        cyc(JAL, 0, 32'h100, 0, 1, 0, 0);
        cyc(BRANCH, 0, 32'h80, 0, 1, 0, 0);
        chk("br_nt_pc", pc, 32'h104);
        chk("br_nt_redirect", {31'b0, redirect}, 32'h0);
        cyc(BRANCH, 0, 32'h82, 0, 1, 0, 0);
        chk("br_nt_misal_pc", pc, 32'h108);
        chk("br_nt_misal_notrap", {31'b0, exc_valid}, 32'h0);

        // Misaligned JALR trap and recovery
        cyc(JAL, 0, 32'h200, 0, 1, 0, 0);
        cyc(JALR, 0, 32'h302, 0, 1, 0, 0);
        chk("mis_exc_valid", {31'b0, exc_valid}, 32'h1);
        chk("mis_cause", {30'b0, exc_cause}, 32'h1);
        chk("mis_exc_pc", exc_pc, 32'h200);
        chk("mis_imem_req", {31'b0, imem_req}, 32'h0);
        chk("mis_pc_hold", pc, 32'h200);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("trap_ignore", pc, 32'h200);
        cyc(OP_ALU, 0, 0, 0, 1, 1, 32'h1000);
        chk("clr_pc", pc, 32'h1000);
        chk("clr_redirect", {31'b0, redirect}, 32'h1);
        chk("clr_cause", {30'b0, exc_cause}, 32'h0);
        chk("clr_imem_req", {31'b0, imem_req}, 32'h1);

        // Timeout after 4 not-ready cycles
        cyc(JAL, 0, 32'h40, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("tmo_3_notrap", {31'b0, exc_valid}, 32'h0);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("tmo_4_trap", {31'b0, exc_valid}, 32'h1);
        chk("tmo_cause", {30'b0, exc_cause}, 32'h2);
        chk("tmo_exc_pc", exc_pc, 32'h40);

        // Stalled cycles do not count toward the timeout
        cyc(OP_ALU, 0, 0, 0, 1, 1, 32'h40);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        cyc(OP_ALU, 0, 0, 1, 0, 0, 0);
        cyc(OP_ALU, 0, 0, 1, 1, 0, 0);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("stl_tmo_notrap", {31'b0, exc_valid}, 32'h0);
        chk("stl_tmo_pc", pc, 32'h40);
        cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("stl_tmo_trap", {31'b0, exc_valid}, 32'h1);

        // An accepted fetch restarts the timeout count
        cyc(OP_ALU, 0, 0, 0, 1, 1, 32'h40);
        for (int i = 0; i < 3; i++) cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("acc_pc", pc, 32'h44);
        for (int i = 0; i < 3; i++) cyc(OP_ALU, 0, 0, 0, 0, 0, 0);
        chk("acc_notrap", {31'b0, exc_valid}, 32'h0);

        // PC wrap and stall priority
        cyc(JAL, 0, 32'hFFFF_FFFC, 0, 1, 0, 0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        opcode = JAL; jb_target = 32'h500; stall = 1'b1; imem_ready = 1'b1;
        #1;
        chk("stall_valid", {31'b0, instr_valid}, 32'h0);
        @(posedge clk); #1;
        chk("stall_pc", pc, 32'h0);
        chk("stall_redirect", {31'b0, redirect}, 32'h0);

        // Asynchronous reset while trapped
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        cyc(JALR, 0, 32'h301, 0, 1, 0, 0);
        chk("pre_rst_trap", {31'b0, exc_valid}, 32'h1);
        chk("pre_rst_epc", exc_pc, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_exc_valid", {31'b0, exc_valid}, 32'h0);
        chk("arst_cause", {30'b0, exc_cause}, 32'h0);
        chk("arst_epc", exc_pc, 32'h0);
        #3 rst_n = 1'b1;
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("rerun_pc0", pc, 32'h0);
        chk("rerun_req", {31'b0, imem_req}, 32'h1);
        cyc(OP_ALU, 0, 0, 0, 1, 0, 0);
        chk("rerun_pc4", pc, 32'h4);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
